// File: rtl/fifo_delay_reader.sv
// Drains a registered-output FIFO one word at a time and re-presents each word on
// a valid/ready port with a programmable idle gap. Optional stats: FIFO_RDR_STATS_EN.
module fifo_delay_reader #(
  parameter int DATA_WIDTH = 4,
  parameter int GAP_WIDTH  = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  input  logic [GAP_WIDTH-1:0]  gap_cycles,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
`ifdef FIFO_RDR_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CAPT,
    ST_PRESENT,
    ST_GAP
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic [GAP_WIDTH-1:0]  r_gap_cnt;
  logic                  w_accept;

  assign w_accept = (r_state == ST_PRESENT) && r_out_valid && out_ready;

  // NOTE: every register in this file uses non-blocking assignments so all
  // flops sample pre-edge values, independent of always-block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_next = r_state;
    fifo_read_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        fifo_read_en = 1'b1;
        w_state_next = ST_CAPT;
      end
      ST_CAPT: begin
        w_state_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (w_accept) begin
          w_state_next = (gap_cycles != '0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        // Counter holds the remaining gap cycles including the current one.
        if (r_gap_cnt <= GAP_WIDTH'(1)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_gap_cnt   <= '0;
    end else begin
      if (r_state == ST_CAPT) begin
        r_out_data  <= fifo_data;
        r_out_valid <= 1'b1;
      end
      if (w_accept) begin
        r_out_valid <= 1'b0;
        r_gap_cnt   <= gap_cycles;
      end else if (r_state == ST_GAP && r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
      end
    end
  end

`ifdef FIFO_RDR_STATS_EN
  logic [CNT_WIDTH-1:0] r_word_count;

  // Saturating: stays at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_count <= '0;
    end else if (w_accept && r_word_count != {CNT_WIDTH{1'b1}}) begin
      r_word_count <= r_word_count + CNT_WIDTH'(1);
    end
  end

  assign word_count = r_word_count;
`else
  // CNT_WIDTH stays a parameter so both builds share one instantiation shape.
  if (CNT_WIDTH < 1) begin : g_cnt_width_unused
  end
`endif

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fifo_delay_reader.sv
// Directed bench for fifo_delay_reader with a registered-output FIFO model.
// Define FIFO_RDR_STATS_EN to also exercise the saturating word counter.
module tb_fifo_delay_reader;

`ifdef FIFO_RDR_STATS_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fifo_empty;
  logic [3:0] fifo_data;
  logic       fifo_read_en;
  logic [3:0] gap_cycles;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef FIFO_RDR_STATS_EN
  logic [TB_CNT_W-1:0] word_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  int         cyc = 0;
  logic [3:0] fifo_q[$];
  int         strobe_t[$];
  int         acc_t[$];
  logic [3:0] acc_d[$];

  always #5 clk = ~clk;

  fifo_delay_reader #(
    .DATA_WIDTH(4),
    .GAP_WIDTH (4),
    .CNT_WIDTH (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read_en(fifo_read_en),
    .gap_cycles  (gap_cycles),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
`ifdef FIFO_RDR_STATS_EN
    ,
    .word_count  (word_count)
`endif
  );

  // FIFO model with registered data and empty flag, plus event logging.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_read_en) begin
      strobe_t.push_back(cyc);
      if (fifo_q.size() != 0) begin
        fifo_data <= fifo_q[0];
        fifo_q.pop_front();
      end
    end
    fifo_empty <= (fifo_q.size() == 0);
    if (out_valid && out_ready) begin
      acc_t.push_back(cyc);
      acc_d.push_back(out_data);
    end
  end

  task automatic clear_logs();
    strobe_t.delete();
    acc_t.delete();
    acc_d.delete();
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    int n = 0;
    while (!out_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run_cycles(2);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int strobes;
    bit ok;
    do_reset();
    tests_run++;
    if ({fifo_read_en, out_valid, busy, out_data} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_state: read_en=%b valid=%b busy=%b data=%h, want all 0",
               fifo_read_en, out_valid, busy, out_data);
    end
`ifdef FIFO_RDR_STATS_EN
    tests_run++;
    if (word_count !== '0) begin
      tests_failed++;
      $display("FAIL reset_word_count: got %0d want 0", word_count);
    end
`endif
    enable = 1'b1;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_read_en) strobes++;
    end
    tests_run++;
    if (strobes != 0) begin
      tests_failed++;
      $display("FAIL empty_no_read: %0d strobes with fifo_empty=1, want 0", strobes);
    end
    out_ready = 1'b0;
    fifo_q.push_back(4'hA);
    wait_valid(20, ok);
    tests_run++;
    if (!ok || out_data !== 4'hA || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL present_before_reset: valid=%b data=%h busy=%b want 1/a/1",
               out_valid, out_data, busy);
    end
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({fifo_read_en, out_valid, busy, out_data} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_present: read_en=%b valid=%b busy=%b data=%h, want all 0",
               fifo_read_en, out_valid, busy, out_data);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    run_cycles(2);
  endtask

  task automatic test_single();
    int re_cnt = 0, re_idx = -1, v_cnt = 0, v_idx = -1;
    logic [3:0] v_data = 4'h0;
    gap_cycles = 4'd0;
    out_ready  = 1'b1;
    enable     = 1'b1;
    fifo_q.push_back(4'h5);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fifo_read_en) begin
        re_cnt++;
        if (re_idx < 0) re_idx = i;
      end
      if (out_valid) begin
        v_cnt++;
        if (v_idx < 0) begin
          v_idx  = i;
          v_data = out_data;
        end
      end
    end
    enable = 1'b0;
    tests_run++;
    if (re_cnt != 1) begin
      tests_failed++;
      $display("FAIL single_strobe_width: read_en high %0d cycles, want 1", re_cnt);
    end
    tests_run++;
    if (re_idx < 0 || v_idx - re_idx != 2) begin
      tests_failed++;
      $display("FAIL single_latency: strobe->valid %0d cycles, want 2", v_idx - re_idx);
    end
    tests_run++;
    if (v_cnt != 1 || v_data !== 4'h5) begin
      tests_failed++;
      $display("FAIL single_data: valid cycles=%0d data=%h, want 1 cycle of 5", v_cnt, v_data);
    end
  endtask

  task automatic test_gap();
    clear_logs();
    gap_cycles = 4'd3;
    out_ready  = 1'b1;
    fifo_q.push_back(4'h1);
    fifo_q.push_back(4'h2);
    fifo_q.push_back(4'h3);
    enable = 1'b1;
    run_cycles(40);
    enable = 1'b0;
    tests_run++;
    if (strobe_t.size() != 3) begin
      tests_failed++;
      $display("FAIL gap_strobe_count: got %0d strobes want 3", strobe_t.size());
    end else begin
      tests_run++;
      if (strobe_t[1] - strobe_t[0] != 7 || strobe_t[2] - strobe_t[1] != 7) begin
        tests_failed++;
        $display("FAIL gap_spacing: got %0d,%0d want 7,7",
                 strobe_t[1] - strobe_t[0], strobe_t[2] - strobe_t[1]);
      end
    end
    tests_run++;
    if (acc_d.size() != 3 || acc_d[0] !== 4'h1 || acc_d[1] !== 4'h2 || acc_d[2] !== 4'h3) begin
      tests_failed++;
      $display("FAIL gap_order: got %0d words %p want 1,2,3", acc_d.size(), acc_d);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int stall_bad = 0;
    int strobes_at_valid;
    clear_logs();
    gap_cycles = 4'd2;
    out_ready  = 1'b0;
    fifo_q.push_back(4'h7);
    fifo_q.push_back(4'h8);
    enable = 1'b1;
    wait_valid(20, ok);
    tests_run++;
    if (!ok || out_data !== 4'h7) begin
      tests_failed++;
      $display("FAIL bp_first_word: valid=%b data=%h want 1/7", out_valid, out_data);
    end
    strobes_at_valid = strobe_t.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) gap_cycles = 4'd5;
      if (out_valid !== 1'b1 || out_data !== 4'h7 || fifo_read_en !== 1'b0) stall_bad++;
    end
    tests_run++;
    if (stall_bad != 0 || strobe_t.size() != strobes_at_valid) begin
      tests_failed++;
      $display("FAIL bp_stall_stable: %0d unstable cycles, strobes %0d->%0d, want 0 and no change",
               stall_bad, strobes_at_valid, strobe_t.size());
    end
    out_ready = 1'b1;
    run_cycles(25);
    enable = 1'b0;
    tests_run++;
    if (acc_t.size() < 1 || strobe_t.size() != 2 || strobe_t[1] - acc_t[0] != 7) begin
      tests_failed++;
      $display("FAIL bp_gap5: accept->next strobe %0d cycles (strobes=%0d), want 7",
               (acc_t.size() > 0 && strobe_t.size() > 1) ? strobe_t[1] - acc_t[0] : -1,
               strobe_t.size());
    end
    tests_run++;
    if (acc_d.size() != 2 || acc_d[0] !== 4'h7 || acc_d[1] !== 4'h8) begin
      tests_failed++;
      $display("FAIL bp_order: got %p want 7,8", acc_d);
    end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    clear_logs();
    gap_cycles = 4'd0;
    out_ready  = 1'b1;
    fifo_q.push_back(4'h9);
    fifo_q.push_back(4'hB);
    enable = 1'b1;
    while (!fifo_read_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    enable = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || fifo_read_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_drop_capt: busy=%b read_en=%b want 1/0", busy, fifo_read_en);
    end
    run_cycles(20);
    tests_run++;
    if (acc_d.size() != 1 || acc_d[0] !== 4'h9 || strobe_t.size() != 1) begin
      tests_failed++;
      $display("FAIL en_drop_complete: accepted %p strobes %0d, want 9 and 1", acc_d, strobe_t.size());
    end
    enable = 1'b1;
    run_cycles(10);
    enable = 1'b0;
    tests_run++;
    if (acc_d.size() != 2 || acc_d[1] !== 4'hB) begin
      tests_failed++;
      $display("FAIL en_resume: accepted %p want 9,b", acc_d);
    end
  endtask

`ifdef FIFO_RDR_STATS_EN
  task automatic test_stats();
    int t;
    logic [TB_CNT_W-1:0] expect_cnt;
    do_reset();
    clear_logs();
    gap_cycles = 4'd0;
    out_ready  = 1'b1;
    for (int i = 0; i < 5; i++) fifo_q.push_back(4'(i + 1));
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      t = 0;
      while (acc_d.size() < k && t < 40) begin
        @(negedge clk);
        t++;
      end
      expect_cnt = (k > 3) ? TB_CNT_W'(3) : TB_CNT_W'(k);
      tests_run++;
      if (acc_d.size() < k || word_count !== expect_cnt) begin
        tests_failed++;
        $display("FAIL stats_word_%0d: word_count=%0d accepted=%0d want %0d",
                 k, word_count, acc_d.size(), expect_cnt);
      end
    end
    enable = 1'b0;
  endtask
`endif

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    gap_cycles = 4'd0;
    out_ready  = 1'b1;
    fifo_empty = 1'b1;
    fifo_data  = 4'h0;
    test_reset();
    test_single();
    test_gap();
    test_backpressure();
    test_enable_drop();
`ifdef FIFO_RDR_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_delay_reader.md
# fifo_delay_reader

Consumer-side companion to the team's delay FIFO. It drains the FIFO's read port one word at a time and re-presents each word on a valid/ready output. A programmable idle gap is enforced between consecutive words. It sits between the FIFO's read side and any downstream pacing-sensitive sink, such as a slow serializer or a display driver.

## Interface
Parameters:
- DATA_WIDTH, 4, width of FIFO words and out_data
- GAP_WIDTH, 4, width of gap_cycles and the internal gap counter
- CNT_WIDTH, 8, width of word_count (used only with FIFO_RDR_STATS_EN)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  permits new FIFO reads; sampled only in IDLE
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  DATA_WIDTH  FIFO registered read data
- fifo_read_en  out  1  FIFO read strobe
- gap_cycles  in  GAP_WIDTH  idle cycles inserted after each accepted word
- out_data  out  DATA_WIDTH  presented word
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts word
- busy  out  1  high whenever state != IDLE
- word_count  out  CNT_WIDTH  accepted-word counter (present only with FIFO_RDR_STATS_EN)

## Operation
- FSM states are IDLE, REQ, CAPT, PRESENT and GAP; encoding is free.
- IDLE → REQ when enable=1 and fifo_empty=0; otherwise the FSM stays in IDLE.
- REQ: fifo_read_en=1, Moore output from state. REQ lasts exactly one cycle, then → CAPT.
- CAPT: fifo_read_en=0. At the exiting edge, out_data ← fifo_data and out_valid ← 1, then → PRESENT.
- PRESENT: out_data and out_valid hold stable until an edge with out_valid=1 and out_ready=1. At that edge:
  - out_valid ← 0.
  - gap_cycles is sampled into the gap counter.
  - The FSM goes → GAP if the sampled value is nonzero, else → IDLE.
- GAP: the counter decrements each cycle. The FSM stays in GAP for exactly the sampled number of cycles, then → IDLE. Changes to gap_cycles during GAP are ignored.
- fifo_read_en is asserted only in REQ, so there are never back-to-back read strobes. There is always at least one non-REQ cycle between strobes, which lets the FIFO's registered empty flag settle.
- enable deasserting outside IDLE does not abort: the in-flight word completes, including its gap.
- out_data holds its last value after acceptance; it is not cleared.
- Reset values: fifo_read_en=0, out_valid=0, out_data=0, busy=0, word_count=0, FSM=IDLE, gap counter=0.
- Reset mid-operation returns to IDLE immediately. A word already strobed out of the FIFO is discarded.

## Timing
- Edge k: FSM enters REQ, so fifo_read_en is high during cycle k..k+1.
- Edge k+1: FIFO samples the strobe; FSM enters CAPT.
- Edge k+2: word is captured; out_valid is high from this edge.
- Read strobe to out_valid latency is 2 cycles.
- Acceptance at edge a with gap G gives the earliest next fifo_read_en at edge a+G+1.
- Maximum throughput with G=0 and out_ready tied high is one word per 4 cycles.
- out_ready low stalls indefinitely in PRESENT with no timeout.
- fifo_empty is ignored outside IDLE.

## Configuration
- Macro FIFO_RDR_STATS_EN.
- Defined:
  - word_count exists.
  - It increments on every out_valid && out_ready edge and saturates at 2^CNT_WIDTH−1 (no wrap).
  - It is cleared only by rst.
- Undefined: word_count port and counter are absent; all other behaviour is identical.

## Test plan
- Reset/idle:
  - Stimulus: assert rst mid-PRESENT with out_data=4'hA.
  - Required: next cycle out_valid=0, out_data=0, busy=0, fifo_read_en=0.
  - Required: with fifo_empty=1 and enable=1, fifo_read_en stays 0 for 20 cycles.
- Single word:
  - Stimulus: FIFO holds 4'h5, gap_cycles=0, out_ready=1.
  - Required: fifo_read_en high for exactly 1 cycle; out_valid high 2 edges later with out_data=4'h5; out_valid low 1 cycle later.
- Gap enforcement:
  - Stimulus: FIFO holds 4'h1, 4'h2, 4'h3; gap_cycles=3; out_ready=1.
  - Required: successive read strobes are exactly 7 cycles apart; outputs arrive in order 1, 2, 3.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid rises, with gap_cycles changed from 2 to 5 during the stall.
  - Required: out_data stable and no new read strobe during the stall; gap=5 applied after acceptance.
- Enable drop:
  - Stimulus: deassert enable during CAPT.
  - Required: that word is still presented and accepted; no further fifo_read_en while enable=0 and the FSM is in IDLE.
- Stats (with FIFO_RDR_STATS_EN, CNT_WIDTH=2):
  - Stimulus: accept 5 words.
  - Required: word_count reads 1, 2, 3, 3, 3.
